// File: rtl/uart_tx_frame.sv
// uart_tx_frame
//   UART transmitter that mirrors the oversampling receiver. It accepts one
//   parallel word per handshake and sends a start bit, the data LSB first, an
//   optional parity bit and the stop bit(s). Each bit is held for Prescale clk
//   cycles, so the bit time matches the receiver running on the same clk.
//
//   Build option: define UART_TX_TWO_STOP_EN to send a second stop bit
//   (STOP2). Without the macro, exactly one stop bit is sent.
//
// Ports
//   clk         in   single clock, all logic on posedge
//   reset_n     in   synchronous active-low reset
//   P_DATA      in   [DATA_WIDTH-1:0] word to send
//   Data_Valid  in   request, accepted only when busy=0
//   PAR_EN      in   1: insert a parity bit
//   PAR_TYP     in   0: even parity, 1: odd parity
//   Prescale    in   [Prescale_width-1:0] clk cycles per bit (0 behaves as 1)
//   TX_OUT      out  serial line, idle high, registered
//   busy        out  high from acceptance to frame end, registered
module uart_tx_frame #(
  parameter int DATA_WIDTH     = 8,
  parameter int Prescale_width = 6
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [Prescale_width-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      busy
);

  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_TWO_STOP_EN
  localparam logic [2:0] STOP2  = 3'd5;
`endif

  logic [2:0]                state;
  logic [Prescale_width-1:0] edge_cnt;
  // Holds Prescale_r-1 so the end-of-bit compare never wraps; Prescale=0 is
  // stored as 0 here, which gives the same 1 cycle/bit as Prescale=1.
  logic [Prescale_width-1:0] presc_last;
  logic [BW-1:0]             bit_cnt;
  logic [DATA_WIDTH-1:0]     data_r;
  logic                      par_en_r;
  logic                      parity_r;
  logic                      last_edge;

  always_comb begin
    last_edge = (edge_cnt == presc_last);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      TX_OUT     <= 1'b1;
      busy       <= 1'b0;
      edge_cnt   <= '0;
      presc_last <= '0;
      bit_cnt    <= '0;
      data_r     <= '0;
      par_en_r   <= 1'b0;
      parity_r   <= 1'b0;
    end else if (state == IDLE) begin
      if (Data_Valid) begin
        state      <= START;
        TX_OUT     <= 1'b0;
        busy       <= 1'b1;
        edge_cnt   <= '0;
        bit_cnt    <= '0;
        data_r     <= P_DATA;
        par_en_r   <= PAR_EN;
        // Parity is fixed at acceptance from the latched word.
        parity_r   <= PAR_TYP ? ~^P_DATA : ^P_DATA;
        presc_last <= (Prescale == '0) ? '0 : Prescale - Prescale_width'(1);
      end
    end else if (!last_edge) begin
      edge_cnt <= edge_cnt + Prescale_width'(1);
    end else begin
      edge_cnt <= '0;
      case (state)
        START: begin
          state   <= DATA;
          TX_OUT  <= data_r[0];
          bit_cnt <= '0;
        end
        DATA: begin
          if (bit_cnt == BIT_LAST) begin
            if (par_en_r) begin
              state  <= PARITY;
              TX_OUT <= parity_r;
            end else begin
              state  <= STOP;
              TX_OUT <= 1'b1;
            end
          end else begin
            // data_r[0] is the bit on the line; shift so the next one is at [0].
            bit_cnt <= bit_cnt + BW'(1);
            data_r  <= {1'b0, data_r[DATA_WIDTH-1:1]};
            TX_OUT  <= data_r[1];
          end
        end
        PARITY: begin
          state  <= STOP;
          TX_OUT <= 1'b1;
        end
`ifdef UART_TX_TWO_STOP_EN
        STOP: begin
          state  <= STOP2;
          TX_OUT <= 1'b1;
        end
        STOP2: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          busy   <= 1'b0;
        end
`else
        STOP: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          busy   <= 1'b0;
        end
`endif
        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
